// File: rtl/logic_gate_sweeper.sv
// Purpose: drives a/b through 00,01,10,11 (LOOPS times) into a two-input gate block,
//          checks and/or/nor/nand/xor against the truth table and reports the results.
// Latency: start sampled at edge 0 -> done pulse in cycle 1+4*LOOPS*(SETTLE_CYCLES+1).
// Backpressure: none; start is only sampled in IDLE, starts while busy/done are dropped.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              sweep request (sampled in IDLE only)
//   busy, done, pass   run status; done is a one-cycle pulse, pass valid from done
//   a, b               registered stimulus to the gate block
//   ow_and..ow_xor     gate block results
//   err_cnt            saturating count of CHECK cycles with any mismatch
//   err_gate           sticky per-gate fail mask {xor,nand,nor,or,and}
//   first_fail_ab      {a,b} of the first mismatching vector, qualified by first_fail_valid
module logic_gate_sweeper #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             a,
  output logic             b,
  input  logic             ow_and,
  input  logic             ow_or,
  input  logic             ow_nor,
  input  logic             ow_nand,
  input  logic             ow_xor,
  output logic [CNT_W-1:0] err_cnt,
  output logic [4:0]       err_gate,
  output logic [1:0]       first_fail_ab,
  output logic             first_fail_valid
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    vec;
  logic [SW-1:0] cnt;
  logic [LW-1:0] loop;

  logic [4:0]    golden;
  logic [4:0]    observed;
  logic [4:0]    mism;
  logic          any_mism;
  logic          last_vec;
  logic          err_sat;

  // Expected results come from vec rather than the a/b flops, so a fault on the
  // stimulus path shows up as a mismatch instead of being masked.
  always_comb begin
    golden   = {vec[1] ^ vec[0], ~(vec[1] & vec[0]), ~(vec[1] | vec[0]),
                vec[1] | vec[0], vec[1] & vec[0]};
    observed = {ow_xor, ow_nand, ow_nor, ow_or, ow_and};
    mism     = golden ^ observed;
    any_mism = |mism;
    last_vec = (vec == 2'd3) && (loop == LW'(LOOPS - 1));
    err_sat  = (err_cnt == {CNT_W{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      vec              <= 2'd0;
      cnt              <= '0;
      loop             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      a                <= 1'b0;
      b                <= 1'b0;
      err_cnt          <= '0;
      err_gate         <= 5'd0;
      first_fail_ab    <= 2'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          a    <= 1'b0;
          b    <= 1'b0;
          if (start) begin
            err_cnt          <= '0;
            err_gate         <= 5'd0;
            first_fail_ab    <= 2'd0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            vec              <= 2'd0;
            loop             <= '0;
            cnt              <= '0;
            busy             <= 1'b1;
            state            <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (cnt == SW'(SETTLE_CYCLES - 1)) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt + SW'(1);
          end
        end

        S_CHECK: begin
          if (any_mism) begin
            if (!err_sat) begin
              err_cnt <= err_cnt + CNT_W'(1);
            end
            err_gate <= err_gate | mism;
            if (!first_fail_valid) begin
              first_fail_ab    <= vec;
              first_fail_valid <= 1'b1;
            end
          end
          if (last_vec) begin
            // pass folds in this final check, which err_cnt only reflects next cycle
            pass  <= (err_cnt == '0) && !any_mism;
            done  <= 1'b1;
            busy  <= 1'b0;
            a     <= 1'b0;
            b     <= 1'b0;
            state <= S_DONE;
          end else begin
            if (vec == 2'd3) begin
              loop <= loop + LW'(1);
            end
            vec      <= vec + 2'd1;
            {a, b}   <= vec + 2'd1;
            cnt      <= '0;
            state    <= S_SETTLE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_sweeper.sv
module tb_logic_gate_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [2:0] busy, done, pass, a, b, ffv;
  logic [2:0] ow_and, ow_or, ow_nor, ow_nand, ow_xor;
  logic [7:0] ec   [3];
  logic [4:0] eg   [3];
  logic [1:0] ffab [3];

  // gate-block model with fault injection: stuck-at mask/value and inversion mask
  logic [4:0] st_en  [3];
  logic [4:0] st_val [3];
  logic [4:0] inv    [3];

  int n_edges = 0;
  int n_chk   = 0;
  int n_fail  = 0;

  typedef struct {
    int         inst;
    int         done_edge;
    logic       p;
    logic [7:0] ec_e;
    logic [4:0] eg_e;
    logic [1:0] ab_e;
    logic       v_e;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) n_edges <= n_edges + 1;

  // inst 0: LOOPS=1 CNT_W=8; inst 1: LOOPS=3 CNT_W=8; inst 2: LOOPS=2 CNT_W=2
  for (genvar i = 0; i < 3; i++) begin : g
    localparam int L  = (i == 1) ? 3 : ((i == 2) ? 2 : 1);
    localparam int CW = (i == 2) ? 2 : 8;
    logic [CW-1:0] ec_w;
    logic [4:0]    gold, gout;

    logic_gate_sweeper #(.SETTLE_CYCLES(2), .LOOPS(L), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .start(start[i]),
      .busy(busy[i]), .done(done[i]), .pass(pass[i]), .a(a[i]), .b(b[i]),
      .ow_and(ow_and[i]), .ow_or(ow_or[i]), .ow_nor(ow_nor[i]),
      .ow_nand(ow_nand[i]), .ow_xor(ow_xor[i]),
      .err_cnt(ec_w), .err_gate(eg[i]), .first_fail_ab(ffab[i]),
      .first_fail_valid(ffv[i])
    );

    assign ec[i] = 8'(ec_w);
    assign gold  = {a[i] ^ b[i], ~(a[i] & b[i]), ~(a[i] | b[i]), a[i] | b[i], a[i] & b[i]};
    assign gout  = (st_en[i] & st_val[i]) | (~st_en[i] & (gold ^ inv[i]));
    assign ow_and[i]  = gout[0];
    assign ow_or[i]   = gout[1];
    assign ow_nor[i]  = gout[2];
    assign ow_nand[i] = gout[3];
    assign ow_xor[i]  = gout[4];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, expv, n_edges);
    end
  endtask

  // monitor: every done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        if (sb.size() == 0 || sb[0].inst != i) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: inst %0d at edge %0d, none expected", i, n_edges);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_edge", n_edges, e.done_edge);
          chk("pass", pass[i], e.p);
          chk("err_cnt", ec[i], e.ec_e);
          chk("err_gate", eg[i], e.eg_e);
          chk("first_fail_valid", ffv[i], e.v_e);
          if (e.v_e) chk("first_fail_ab", ffab[i], e.ab_e);
        end
      end
    end
  end

  task automatic go(input int i, input int delay, input logic p, input logic [7:0] ec_e,
                    input logic [4:0] eg_e, input logic [1:0] ab_e, input logic v_e,
                    input bit push);
    @(negedge clk);
    start[i] = 1'b1;
    if (push) sb.push_back('{i, n_edges + 1 + delay, p, ec_e, eg_e, ab_e, v_e});
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expected done pulses never seen", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 3'b000;
    for (int i = 0; i < 3; i++) begin
      st_en[i]  = 5'd0;
      st_val[i] = 5'd0;
      inv[i]    = 5'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("reset_state", {busy[i], done[i], pass[i], a[i], b[i], ffv[i], ffab[i], eg[i], ec[i]}, 0);
    rst = 1'b0;

    // 1: golden gates
    go(0, 12, 1'b1, 8'd0, 5'b00000, 2'b00, 1'b0, 1'b1);
    drain();
    chk("pass_hold", pass[0], 1'b1);

    // 2: xor stuck-0 fails on 01 and 10
    st_en[0] = 5'b10000; st_val[0] = 5'b00000;
    go(0, 12, 1'b0, 8'd2, 5'b10000, 2'b01, 1'b1, 1'b1);
    drain();
    repeat (5) @(negedge clk);
    chk("err_cnt_hold", ec[0], 8'd2);
    chk("pass_hold_fail", pass[0], 1'b0);

    // 3: LOOPS=3, and stuck-1 fails on 00,01,10 each loop
    st_en[1] = 5'b00001; st_val[1] = 5'b00001;
    go(1, 36, 1'b0, 8'd9, 5'b00001, 2'b00, 1'b1, 1'b1);
    drain();

    // 4: start held high 40 cycles -> accepted every 14 cycles
    st_en[0] = 5'b00000;
    @(negedge clk);
    start[0] = 1'b1;
    sb.push_back('{0, n_edges + 1 + 12, 1'b1, 8'd0, 5'd0, 2'b00, 1'b0});
    sb.push_back('{0, n_edges + 1 + 26, 1'b1, 8'd0, 5'd0, 2'b00, 1'b0});
    sb.push_back('{0, n_edges + 1 + 40, 1'b1, 8'd0, 5'd0, 2'b00, 1'b0});
    repeat (5) @(negedge clk);
    chk("busy_held_start", busy[0], 1'b1);
    repeat (35) @(negedge clk);
    start[0] = 1'b0;
    drain();

    // 5: reset mid-sweep with and stuck-1, then a clean run
    st_en[0] = 5'b00001; st_val[0] = 5'b00001;
    go(0, 0, 1'b0, 8'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_busy", busy[0], 1'b1);
    chk("mid_ab", {a[0], b[0]}, 2'b01);
    chk("mid_err_cnt", ec[0], 8'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_ab", {a[0], b[0]}, 2'b00);
    chk("rst_err_cnt", ec[0], 8'd0);
    chk("rst_err_gate", eg[0], 5'd0);
    chk("rst_ffv", ffv[0], 1'b0);
    chk("rst_done", done[0], 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    st_en[0] = 5'b00000;
    go(0, 12, 1'b1, 8'd0, 5'd0, 2'b00, 1'b0, 1'b1);
    drain();

    // 6: CNT_W=2, LOOPS=2, every gate inverted -> 8 mismatches, saturates at 3
    inv[2] = 5'b11111;
    go(2, 24, 1'b0, 8'd3, 5'b11111, 2'b00, 1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
